// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerometer signed-to-BCD converter:
//   - st_t       : converter FSM state encoding
//   - BCD_W      : width of one BCD digit
//   - sat_limit  : largest value representable in a given number of digits
// No ports (package).
// ---------------------------------------------------------------------------
package accel_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } st_t;

  // 10^digits - 1, evaluated at elaboration time for the saturation compare.
  function automatic logic [63:0] sat_limit(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// ---------------------------------------------------------------------------
// bcd_dd_core
// Single-channel sequential double-dabble engine. One load cycle, then
// DATA_W step cycles; after the last step bcd holds the low DIGITS digits
// of the unsigned magnitude.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : clear accumulator, load magnitude, reset step count
//   step         : one add-3 / shift-left iteration
//   mag          : unsigned magnitude to convert
//   bcd          : BCD accumulator, digit 0 (units) in bits [3:0]
//   last         : high while the step in progress is the final one
// ---------------------------------------------------------------------------
module bcd_dd_core
  import accel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [DATA_W-1:0]         mag,
  output logic [DIGITS*BCD_W-1:0]   bcd,
  output logic                      last
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       shreg;
  logic [CNT_W-1:0]        cnt;
  logic [DIGITS*BCD_W-1:0] adj;

  // Any digit of 5 or more would exceed 9 after doubling, so bias it by 3
  // first; the carry then lands in the next digit after the shift.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*BCD_W +: BCD_W] >= 4'd5) begin
        adj[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  // Digits above DIGITS are simply dropped; the top level replaces the
  // result with all nines whenever that truncation could matter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      bcd   <= '0;
      shreg <= mag;
      cnt   <= '0;
    end else if (step) begin
      bcd   <= {adj[DIGITS*BCD_W-2:0], shreg[DATA_W-1]};
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/accel_bcd_conv.sv
// ---------------------------------------------------------------------------
// accel_bcd_conv
// Multi-channel signed-to-BCD converter. Captures one packed sample, converts
// each channel in turn through a shared double-dabble core, and publishes all
// channels together with a one-cycle out_valid pulse.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   in_valid     : sample strobe, taken only when idle and not frozen
//   in_data      : packed samples, channel c at [c*DATA_W +: DATA_W]
//   freeze       : ignore in_valid, hold outputs
//   clr_overrun  : clear sticky overrun (wins over a simultaneous set)
//   bcd_out      : channel c digit d at [(c*DIGITS+d)*4 +: 4], d=0 units
//   sign_out     : per-channel negative flag
//   ovf_out      : per-channel saturation flag
//   out_valid    : one-cycle pulse when outputs update
//   busy         : conversion in progress
//   overrun      : sticky, a sample arrived while busy
// ---------------------------------------------------------------------------
module accel_bcd_conv
  import accel_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 16,
  parameter int DIGITS   = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  input  logic [CHANNELS*DATA_W-1:0]       in_data,
  input  logic                             freeze,
  input  logic                             clr_overrun,
  output logic [CHANNELS*DIGITS*BCD_W-1:0] bcd_out,
  output logic [CHANNELS-1:0]              sign_out,
  output logic [CHANNELS-1:0]              ovf_out,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int              CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int              CH_BCD_W  = DIGITS * BCD_W;
  localparam logic [63:0]     SAT_LIM   = sat_limit(DIGITS);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CHANNELS - 1);

  st_t                             state;
  st_t                             next_state;
  logic [CHANNELS*DATA_W-1:0]      cap;
  logic [CH_W-1:0]                 ch;
  logic [DATA_W-1:0]               cur;
  logic [DATA_W-1:0]               mag;
  logic                            cur_sign;
  logic                            cur_sat;
  logic                            accept;
  logic                            drop;
  logic                            core_load;
  logic                            core_step;
  logic                            core_last;
  logic [CH_BCD_W-1:0]             core_bcd;
  logic [CHANNELS*CH_BCD_W-1:0]    shadow_bcd;
  logic [CHANNELS-1:0]             shadow_sign;
  logic [CHANNELS-1:0]             shadow_ovf;

  assign accept = in_valid && !freeze && (state == ST_IDLE);
  assign drop   = in_valid && !freeze && (state != ST_IDLE);
  assign busy   = (state != ST_IDLE);

  // The capture register is stable for the whole conversion, so sign and
  // saturation can be derived combinationally in both LOAD and STORE.
  // The most negative input negates to itself, which read as unsigned is
  // exactly its magnitude.
  assign cur      = cap[int'(ch)*DATA_W +: DATA_W];
  assign cur_sign = cur[DATA_W-1];
  assign mag      = cur_sign ? (~cur + 1'b1) : cur;
  assign cur_sat  = (64'(mag) > SAT_LIM);

  bcd_dd_core #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (core_load),
    .step    (core_step),
    .mag     (mag),
    .bcd     (core_bcd),
    .last    (core_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and core control. Every channel takes the same number of
  // cycles, so latency does not depend on the data or on saturation.
  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        core_load  = 1'b1;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        core_step = 1'b1;
        if (core_last) next_state = ST_STORE;
      end
      ST_STORE: begin
        next_state = (ch == LAST_CH) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Capture, per-channel shadow results, atomic publish and overrun flag.
  // Outputs only move in DONE, so a consumer never sees a mixed sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap         <= '0;
      ch          <= '0;
      shadow_bcd  <= '0;
      shadow_sign <= '0;
      shadow_ovf  <= '0;
      bcd_out     <= '0;
      sign_out    <= '0;
      ovf_out     <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (accept) begin
        cap <= in_data;
        ch  <= '0;
      end

      if (state == ST_STORE) begin
        shadow_bcd[int'(ch)*CH_BCD_W +: CH_BCD_W] <= cur_sat ? {DIGITS{4'h9}} : core_bcd;
        shadow_sign[ch] <= cur_sign;
        shadow_ovf[ch]  <= cur_sat;
        if (ch != LAST_CH) ch <= ch + 1'b1;
      end

      if (state == ST_DONE) begin
        bcd_out   <= shadow_bcd;
        sign_out  <= shadow_sign;
        ovf_out   <= shadow_ovf;
        out_valid <= 1'b1;
      end

      if (clr_overrun) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_accel_bcd_conv
// Directed bench for accel_bcd_conv: a default-parameter instance and a
// CHANNELS=1 / DATA_W=10 / DIGITS=3 instance sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_accel_bcd_conv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [47:0] in_data;
  logic        freeze;
  logic        clr_overrun;
  logic [47:0] bcd_out;
  logic [2:0]  sign_out;
  logic [2:0]  ovf_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic        s_in_valid;
  logic [9:0]  s_in_data;
  logic [11:0] s_bcd_out;
  logic [0:0]  s_sign_out;
  logic [0:0]  s_ovf_out;
  logic        s_out_valid;
  logic        s_busy;
  logic        s_overrun;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [47:0] DATA_A = 48'h0000_FE0C_01F4;
  localparam logic [47:0] EXP_A  = 48'h0000_0500_0500;
  localparam logic [47:0] DATA_B = 48'h2710_270F_8000;
  localparam logic [47:0] EXP_B  = 48'h9999_9999_9999;

  always #5 clk = ~clk;

  accel_bcd_conv dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .freeze      (freeze),
    .clr_overrun (clr_overrun),
    .bcd_out     (bcd_out),
    .sign_out    (sign_out),
    .ovf_out     (ovf_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  accel_bcd_conv #(
    .CHANNELS (1),
    .DATA_W   (10),
    .DIGITS   (3)
  ) dut_s (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (s_in_valid),
    .in_data     (s_in_data),
    .freeze      (freeze),
    .clr_overrun (clr_overrun),
    .bcd_out     (s_bcd_out),
    .sign_out    (s_sign_out),
    .ovf_out     (s_ovf_out),
    .out_valid   (s_out_valid),
    .busy        (s_busy),
    .overrun     (s_overrun)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a sample for one clock; returns #1 after the accepting edge.
  task automatic apply_stimulus(input int sel, input logic [47:0] data);
    @(negedge clk);
    if (sel == 0) begin
      in_valid = 1'b1;
      in_data  = data;
    end else begin
      s_in_valid = 1'b1;
      s_in_data  = data[9:0];
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen; -1 if the budget runs out.
  task automatic wait_valid(input int sel, input int budget, output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
      if ((sel == 0 && out_valid) || (sel != 0 && s_out_valid)) found = 1'b1;
    end
    if (!found) lat = -1;
  endtask

  initial begin
    int lat;
    int seen;

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    freeze      = 1'b0;
    clr_overrun = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_bcd", 64'(bcd_out), 64'h0);
    check_output("rst_sign", 64'(sign_out), 64'h0);
    check_output("rst_ovf", 64'(ovf_out), 64'h0);
    check_output("rst_valid", 64'(out_valid), 64'h0);
    check_output("rst_busy", 64'(busy), 64'h0);
    check_output("rst_overrun", 64'(overrun), 64'h0);
    reset_n = 1'b1;

    // +500, -500, 0.
    $display("[TB] basic conversion");
    apply_stimulus(0, DATA_A);
    check_output("a_busy", 64'(busy), 64'h1);
    wait_valid(0, 100, lat);
    check_output("a_latency", 64'(lat), 64'd55);
    check_output("a_bcd", 64'(bcd_out), 64'(EXP_A));
    check_output("a_sign", 64'(sign_out), 64'h2);
    check_output("a_ovf", 64'(ovf_out), 64'h0);
    check_output("a_busy_idle", 64'(busy), 64'h0);

    // Back-to-back: present the next sample in the out_valid cycle.
    $display("[TB] back-to-back saturation sample");
    in_valid = 1'b1;
    in_data  = DATA_B;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("b_accept_busy", 64'(busy), 64'h1);
    check_output("b_valid_pulse", 64'(out_valid), 64'h0);
    wait_valid(0, 100, lat);
    check_output("b_latency", 64'(lat), 64'd55);
    check_output("b_bcd", 64'(bcd_out), 64'(EXP_B));
    check_output("b_sign", 64'(sign_out), 64'h1);
    check_output("b_ovf", 64'(ovf_out), 64'h5);
    check_output("b_overrun", 64'(overrun), 64'h0);

    // Sample arriving mid-conversion is dropped and flagged.
    $display("[TB] overrun");
    apply_stimulus(0, DATA_A);
    repeat (9) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_B;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("ov_set", 64'(overrun), 64'h1);
    wait_valid(0, 100, lat);
    check_output("ov_latency", 64'(lat), 64'd45);
    check_output("ov_bcd", 64'(bcd_out), 64'(EXP_A));
    check_output("ov_sign", 64'(sign_out), 64'h2);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    check_output("ov_clear", 64'(overrun), 64'h0);

    // Reset at cycle 20 of a conversion.
    $display("[TB] reset mid-conversion");
    apply_stimulus(0, DATA_B);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("mr_busy", 64'(busy), 64'h0);
    check_output("mr_bcd", 64'(bcd_out), 64'h0);
    check_output("mr_sign", 64'(sign_out), 64'h0);
    check_output("mr_ovf", 64'(ovf_out), 64'h0);
    check_output("mr_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    check_output("mr_no_output", 64'(seen), 64'h0);
    apply_stimulus(0, DATA_A);
    wait_valid(0, 100, lat);
    check_output("mr_latency", 64'(lat), 64'd55);
    check_output("mr_bcd_after", 64'(bcd_out), 64'(EXP_A));

    // Freeze: strobes are ignored and do not count as overrun.
    $display("[TB] freeze");
    @(negedge clk);
    freeze = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, DATA_B);
      if (busy) seen++;
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    check_output("fz_no_conv", 64'(seen), 64'h0);
    check_output("fz_overrun", 64'(overrun), 64'h0);
    check_output("fz_hold", 64'(bcd_out), 64'(EXP_A));
    @(negedge clk);
    freeze = 1'b0;
    apply_stimulus(0, DATA_B);
    wait_valid(0, 100, lat);
    check_output("fz_latency", 64'(lat), 64'd55);
    check_output("fz_bcd", 64'(bcd_out), 64'(EXP_B));
    check_output("fz_ovf", 64'(ovf_out), 64'h5);

    // Reduced configuration: 1 channel, 10 bits, 3 digits.
    $display("[TB] small configuration");
    apply_stimulus(1, 48'h3FF);
    wait_valid(1, 40, lat);
    check_output("s1_latency", 64'(lat), 64'd13);
    check_output("s1_bcd", 64'(s_bcd_out), 64'h001);
    check_output("s1_sign", 64'(s_sign_out), 64'h1);
    check_output("s1_ovf", 64'(s_ovf_out), 64'h0);
    apply_stimulus(1, 48'h200);
    wait_valid(1, 40, lat);
    check_output("s2_latency", 64'(lat), 64'd13);
    check_output("s2_bcd", 64'(s_bcd_out), 64'h512);
    check_output("s2_sign", 64'(s_sign_out), 64'h1);
    apply_stimulus(1, 48'h1F3);
    wait_valid(1, 40, lat);
    check_output("s3_bcd", 64'(s_bcd_out), 64'h499);
    check_output("s3_sign", 64'(s_sign_out), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
